// File: rtl/parking_pkg.sv
// parking_pkg: shared FSM states and constants for the parking gate controller
package parking_pkg;
  localparam int SLOT_W = 3;
  localparam int DEF_TIME_W = 11;
  localparam int DEF_RATE = 1;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ALLOC    = 3'd1,
    S_GATE_IN  = 3'd2,
    S_CALC     = 3'd3,
    S_GATE_OUT = 3'd4
  } state_e;
endpackage

// File: rtl/parking_slot_alloc.sv
// parking_slot_alloc: lowest-free-bay priority encoder over the occupancy vector
module parking_slot_alloc
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS = 6
) (
  input  logic [NUM_SLOTS-1:0] occupied_i,
  output logic                 found_o,
  output logic [SLOT_W-1:0]    index_o
);
  // scan from the top so the last hit written is the lowest free bay
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (!occupied_i[i]) begin
        found_o = 1'b1;
        index_o = SLOT_W'(i);
      end
  end
endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: entry/exit arbitration, bay allocation, fee calculation and gate timing
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS   = 6,
  parameter int TIME_W      = DEF_TIME_W,
  parameter int RATE        = DEF_RATE,
  parameter int GATE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 in_req,
  input  logic                 out_req,
  input  logic [SLOT_W-1:0]    out_slot,
  output logic                 in_ack,
  output logic                 out_ack,
  output logic [SLOT_W-1:0]    slot_assigned,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic                 full,
  output logic                 gate_in_open,
  output logic                 gate_out_open,
  output logic [TIME_W+7:0]    fee,
  output logic                 fee_valid,
  output logic                 err,
  output logic [TIME_W-1:0]    now
);
  localparam int FEE_W = TIME_W + 8;
  localparam int CNT_W = GATE_CYCLES > 1 ? $clog2(GATE_CYCLES) : 1;
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 last_out_q, last_out_d;
  logic [NUM_SLOTS-1:0] occ_q, occ_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [FEE_W-1:0]     fee_q, fee_d, fee_calc;
  logic                 fee_valid_q;
  logic [TIME_W-1:0]    now_q;
  logic [TIME_W-1:0]    stamp_q [NUM_SLOTS];
  logic [TIME_W-1:0]    stamp_sel, elapsed;
  logic [NUM_SLOTS-1:0] sel;
  logic                 hit, found, take_in, take_out, gate_done;
  logic [SLOT_W-1:0]    free_idx;

  parking_slot_alloc #(.NUM_SLOTS(NUM_SLOTS)) u_alloc (
    .occupied_i (occ_q),
    .found_o    (found),
    .index_o    (free_idx)
  );

  // one-hot decode of the exit bay; out-of-range numbers simply match nothing
  always_comb begin
    sel = '0;
    stamp_sel = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (out_slot == SLOT_W'(i + 1)) begin
        sel[i] = 1'b1;
        stamp_sel = stamp_q[i];
      end
  end

  assign hit = |(sel & occ_q);
  assign elapsed = now_q - stamp_sel;
  assign fee_calc = (elapsed == '0 ? FEE_W'(1) : FEE_W'(elapsed)) * FEE_W'(RATE);
  assign full = &occ_q;
  // entry is eligible only with a free bay; on contention alternate sides
  assign take_in = in_req && !full && (!out_req || last_out_q);
  assign take_out = out_req && !take_in;
  assign gate_done = cnt_q == CNT_W'(GATE_CYCLES - 1);

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_out_d = last_out_q;
    occ_d = occ_q;
    slot_d = slot_q;
    fee_d = fee_q;
    case (state_q)
      S_IDLE: begin
        state_d = take_in ? S_ALLOC : take_out ? S_CALC : S_IDLE;
        last_out_d = take_in ? 1'b0 : take_out ? 1'b1 : last_out_q;
      end
      S_ALLOC: begin
        state_d = S_GATE_IN;
        cnt_d = '0;
        occ_d = found ? occ_q | (NUM_SLOTS'(1) << free_idx) : occ_q;
        slot_d = found ? free_idx + 1'b1 : slot_q;
      end
      S_CALC: begin
        state_d = hit ? S_GATE_OUT : S_IDLE;
        cnt_d = '0;
        occ_d = hit ? occ_q & ~sel : occ_q;
        fee_d = hit ? fee_calc : fee_q;
      end
      S_GATE_IN, S_GATE_OUT: begin
        state_d = gate_done ? S_IDLE : state_q;
        cnt_d = gate_done ? cnt_q : cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      last_out_q <= 1'b1;
      occ_q <= '0;
      slot_q <= '0;
      fee_q <= '0;
      fee_valid_q <= 1'b0;
      now_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) stamp_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_out_q <= last_out_d;
      occ_q <= occ_d;
      slot_q <= slot_d;
      fee_q <= fee_d;
      fee_valid_q <= state_q == S_CALC && hit;
      now_q <= tick ? now_q + 1'b1 : now_q;
      if (state_q == S_ALLOC && found) stamp_q[free_idx] <= now_q;
    end

  assign in_ack = state_q == S_ALLOC;
  assign out_ack = state_q == S_CALC;
  assign err = out_ack && !hit;
  assign gate_in_open = state_q == S_GATE_IN;
  assign gate_out_open = state_q == S_GATE_OUT;
  assign slot_assigned = slot_q;
  assign occupied = occ_q;
  assign fee = fee_q;
  assign fee_valid = fee_valid_q;
  assign now = now_q;
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: table vectors, directed corner cases and a random phase against a transaction-level model
module tb_parking_gate_ctrl;
  localparam int G = 4;
  localparam int RT = 2;
  localparam int NS = 6;
  localparam int TMOD = 2048;

  typedef struct {
    bit         ex;
    logic [2:0] slot;
    int         at;
    logic [2:0] e_slot;
    int         e_fee;
    bit         e_err;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, in_req = 1'b0, out_req = 1'b0;
  logic [2:0] out_slot = '0;
  logic in_ack, out_ack, full, gate_in_open, gate_out_open, fee_valid, err;
  logic [2:0] slot_assigned;
  logic [5:0] occupied;
  logic [18:0] fee;
  logic [10:0] now;

  int total = 0, bad = 0, mnow = 0, mfee = 0, cyc = 0;
  bit mocc [NS];
  int mstamp [NS];
  bit rnd_tick = 1'b0;

  parking_gate_ctrl #(.NUM_SLOTS(NS), .TIME_W(11), .RATE(RT), .GATE_CYCLES(G)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick          (tick),
    .in_req        (in_req),
    .out_req       (out_req),
    .out_slot      (out_slot),
    .in_ack        (in_ack),
    .out_ack       (out_ack),
    .slot_assigned (slot_assigned),
    .occupied      (occupied),
    .full          (full),
    .gate_in_open  (gate_in_open),
    .gate_out_open (gate_out_open),
    .fee           (fee),
    .fee_valid     (fee_valid),
    .err           (err),
    .now           (now)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) mnow <= 0;
    else if (tick) mnow <= (mnow + 1) % TMOD;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] occ_vec();
    logic [5:0] v;
    for (int i = 0; i < NS; i++) v[i] = mocc[i];
    return v;
  endfunction

  function automatic int mfree();
    for (int i = 0; i < NS; i++) if (!mocc[i]) return i;
    return -1;
  endfunction

  task automatic step();
    @(negedge clk);
    tick = rnd_tick ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic advance(int to);
    int n;
    n = 0;
    while (mnow != to && n < 3000) begin
      tick = 1'b1;
      @(negedge clk);
      n++;
    end
    tick = 1'b0;
  endtask

  task automatic wait_ack(bit ex, output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!(ex ? out_ack : in_ack) && lat < 40);
    chk(ex ? "out_ack seen" : "in_ack seen", 32'(ex ? out_ack : in_ack), 1);
  endtask

  task automatic entry_tail();
    int b, gc, xa;
    b = mfree();
    chk("entry now", 32'(now), 32'(mnow));
    if (b >= 0) begin
      mocc[b] = 1'b1;
      mstamp[b] = mnow;
    end
    in_req = 1'b0;
    gc = 0;
    xa = 0;
    for (int i = 0; i <= G; i++) begin
      step();
      if (i == 0) begin
        chk("gate_in at k+2", 32'(gate_in_open), 1);
        chk("slot_assigned", 32'(slot_assigned), 32'(b + 1));
        chk("occupied after entry", 32'(occ_vec()), 32'(occupied));
      end
      gc += int'(gate_in_open);
      xa += int'(in_ack) + int'(out_ack);
    end
    chk("gate_in cycles", 32'(gc), G);
    chk("extra acks during entry", 32'(xa), 0);
  endtask

  task automatic exit_tail(input logic [2:0] s, output logic e);
    int si, el, gc, fv, ec;
    bit v;
    si = int'(s);
    v = si >= 1 && si <= NS && mocc[si - 1];
    e = err;
    chk("err at calc", 32'(err), 32'(!v));
    chk("exit now", 32'(now), 32'(mnow));
    if (v) begin
      el = (mnow - mstamp[si - 1] + TMOD) % TMOD;
      if (el == 0) el = 1;
      mfee = el * RT;
      mocc[si - 1] = 1'b0;
    end
    out_req = 1'b0;
    gc = 0;
    fv = 0;
    ec = 0;
    for (int i = 0; i <= G; i++) begin
      step();
      if (i == 0) begin
        chk("gate_out at k+2", 32'(gate_out_open), 32'(v));
        chk("fee_valid at k+2", 32'(fee_valid), 32'(v));
      end
      gc += int'(gate_out_open);
      fv += int'(fee_valid);
      ec += int'(err);
    end
    chk("gate_out cycles", 32'(gc), v ? G : 0);
    chk("fee_valid pulses", 32'(fv), 32'(v));
    chk("err extra cycles", 32'(ec), 0);
    chk("fee", 32'(fee), 32'(mfee));
    chk("occupied after exit", 32'(occupied), 32'(occ_vec()));
  endtask

  task automatic do_entry(output logic [2:0] got, output int lat);
    in_req = 1'b1;
    wait_ack(1'b0, lat);
    entry_tail();
    got = slot_assigned;
  endtask

  task automatic do_exit(input logic [2:0] s, output logic e);
    int lat;
    out_slot = s;
    out_req = 1'b1;
    wait_ack(1'b1, lat);
    exit_tail(s, e);
  endtask

  initial begin
    vec_t tbl [11];
    logic [2:0] got, s;
    logic e;
    int lat, xa, c0, cand [$];
    // RATE=2 in this bench, so every fee is twice the billed elapsed time
    tbl[0]  = '{1'b0, 3'd0, 0,    3'd1, 0,  1'b0};
    tbl[1]  = '{1'b0, 3'd0, 100,  3'd2, 0,  1'b0};
    tbl[2]  = '{1'b1, 3'd2, 130,  3'd0, 60, 1'b0};
    tbl[3]  = '{1'b1, 3'd4, 130,  3'd0, 60, 1'b1};
    tbl[4]  = '{1'b1, 3'd7, 130,  3'd0, 60, 1'b1};
    tbl[5]  = '{1'b1, 3'd0, 130,  3'd0, 60, 1'b1};
    tbl[6]  = '{1'b0, 3'd0, 2040, 3'd2, 60, 1'b0};
    tbl[7]  = '{1'b1, 3'd2, 5,    3'd0, 26, 1'b0};
    tbl[8]  = '{1'b0, 3'd0, 5,    3'd2, 26, 1'b0};
    tbl[9]  = '{1'b1, 3'd2, 5,    3'd0, 2,  1'b0};
    tbl[10] = '{1'b1, 3'd1, 5,    3'd0, 10, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset occupied", 32'(occupied), 0);
    chk("reset now", 32'(now), 0);
    chk("reset fee", 32'(fee), 0);
    chk("reset slot_assigned", 32'(slot_assigned), 0);
    chk("reset strobes", 32'({in_ack, out_ack, full, gate_in_open, gate_out_open, fee_valid, err}), 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      advance(tbl[i].at);
      if (tbl[i].ex) begin
        do_exit(tbl[i].slot, e);
        chk($sformatf("vec%0d err", i), 32'(e), 32'(tbl[i].e_err));
      end else begin
        do_entry(got, lat);
        chk($sformatf("vec%0d slot", i), 32'(got), 32'(tbl[i].e_slot));
        chk($sformatf("vec%0d ack latency", i), 32'(lat), 1);
      end
      chk($sformatf("vec%0d fee", i), 32'(fee), 32'(tbl[i].e_fee));
    end

    // fill the lot, then an entry must wait until an exit frees bay 3
    repeat (NS) do_entry(got, lat);
    chk("full flag", 32'(full), 1);
    in_req = 1'b1;
    xa = 0;
    repeat (8) begin
      step();
      xa += int'(in_ack);
    end
    chk("no in_ack while full", 32'(xa), 0);
    do_exit(3'd3, e);
    wait_ack(1'b0, lat);
    chk("pending entry latency", 32'(lat), 1);
    entry_tail();
    chk("pending entry slot", 32'(slot_assigned), 3);

    // simultaneous requests after an exit: entry first, exit GATE_CYCLES+2 later
    do_exit(3'd5, e);
    out_slot = 3'd1;
    in_req = 1'b1;
    out_req = 1'b1;
    wait_ack(1'b0, lat);
    chk("contention out_ack held off", 32'(out_ack), 0);
    c0 = cyc;
    entry_tail();
    wait_ack(1'b1, lat);
    chk("contention exit spacing", 32'(cyc - c0), G + 2);
    exit_tail(3'd1, e);

    // asynchronous reset in the middle of an open exit gate
    out_slot = 3'd2;
    out_req = 1'b1;
    wait_ack(1'b1, lat);
    out_req = 1'b0;
    step();
    step();
    chk("gate_out before reset", 32'(gate_out_open), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("gate_out async drop", 32'(gate_out_open), 0);
    chk("occupied in reset", 32'(occupied), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NS; i++) mocc[i] = 1'b0;
    mfee = 0;
    step();
    chk("occupied after reset", 32'(occupied), 0);
    chk("now after reset", 32'(now), 0);
    chk("fee after reset", 32'(fee), 0);

    rnd_tick = 1'b1;
    repeat (80) begin
      if ($urandom_range(0, 3) == 0) begin
        tick = 1'b1;
        repeat ($urandom_range(1, 700)) @(negedge clk);
        tick = 1'b0;
      end
      if (mfree() >= 0 && $urandom_range(0, 1) == 0) do_entry(got, lat);
      else begin
        cand.delete();
        for (int i = 0; i < NS; i++) if (mocc[i]) cand.push_back(i + 1);
        s = (cand.size() == 0 || $urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                              : 3'(cand[$urandom_range(0, cand.size() - 1)]);
        do_exit(s, e);
      end
      chk("random now", 32'(now), 32'(mnow));
      chk("random full", 32'(full), 32'(mfree() < 0));
    end
    rnd_tick = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
